// File: rtl/serial_capture_pkg.sv
// Shared constants and types for the serial capture block.
// Default geometry and deserializer state encoding.
package serial_capture_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

endpackage

// File: rtl/serial_capture_fifo.sv
// Synchronous FIFO holding assembled capture words.
// Power-of-two depth; pointers wrap naturally.
module capture_fifo
   import serial_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot for a push while full
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wp] <= wdata;
   end

endmodule

// File: rtl/serial_capture.sv
// LSB-first serial deserializer feeding a small output FIFO.
// Words that find the FIFO full are dropped and flagged sticky.
module serial_capture
   import serial_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bit_in,
   input  logic                       bit_en,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int BW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [BW-1:0]    bcnt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] word;
   logic             last;
   logic             push;
   logic             full;
   logic             empty;
   logic             drop;

   assign last = bit_en && (bcnt == BW'(WIDTH - 1));
   assign push = last;
   assign drop = push && full && !(out_ready && !empty);

   always_comb begin
      word       = sr;
      word[bcnt] = bit_in;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (bit_en) state_nx = SHIFT;
         SHIFT: if (last)   state_nx = IDLE;
         default:           state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bcnt     <= '0;
         sr       <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nx;
         if (bit_en) begin
            // partial word clears once the full word leaves for the FIFO
            if (last) begin
               bcnt <= '0;
               sr   <= '0;
            end else begin
               bcnt <= bcnt + 1'b1;
               sr   <= word;
            end
         end
         if (drop) overflow <= 1'b1;
      end
   end

   capture_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (word),
      .pop   (out_ready),
      .rdata (out_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign out_valid = !empty;

endmodule

// File: doc/serial_capture.md
SERIAL_CAPTURE -- requirements
Module: serial_capture

Interface
REQ-001 Parameter WIDTH, default 8, bits per captured word (2..32).
REQ-002 Parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 bit_in  input  1  serial data bit, typically the registered q of the upstream flop.
REQ-006 bit_en  input  1  qualifies bit_in; bit consumed only when high.
REQ-007 out_data  output  WIDTH  head-of-FIFO word.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-010 count  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-011 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 Deserializer SHALL shift bit_in LSB-first: first accepted bit lands in bit 0 of the assembled word.
REQ-013 Bit counter SHALL run 0..WIDTH-1, incrementing only on bit_en cycles, wrapping to 0 after the WIDTH-th bit.
REQ-014 Deserializer state machine SHALL have states IDLE (counter 0, no partial word) and SHIFT (1..WIDTH-1 bits held); IDLE->SHIFT on bit_en; SHIFT->IDLE on WIDTH-th bit_en.
REQ-015 On the WIDTH-th accepted bit, the complete word SHALL be pushed into the FIFO on that same clock edge.
REQ-016 Latency: with an empty FIFO, out_valid SHALL rise and out_data SHALL show the word in the cycle immediately after the final bit_en cycle.
REQ-017 A pop occurs when out_valid && out_ready; out_ready while out_valid low SHALL have no effect.
REQ-018 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-019 Push while full and no pop SHALL drop the new word, leave FIFO contents unchanged, and set overflow.
REQ-020 Simultaneous push and pop while full SHALL accept the push; count unchanged; overflow not set.
REQ-021 Simultaneous push and pop while count==1 SHALL keep out_valid high and present the new word next cycle.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH exactly.
REQ-023 overflow SHALL remain set until rst; further drops have no additional effect.
REQ-024 Deserializer SHALL keep accepting bits regardless of FIFO state (no backpressure upstream).

Reset
REQ-025 rst SHALL force: bit counter 0, state IDLE, partial word 0, pointers 0, count 0, out_valid 0, overflow 0, out_data 0.
REQ-026 rst asserted mid-word SHALL discard the partial word; a bit_en in the reset cycle SHALL be ignored.
REQ-027 rst SHALL take priority over push and pop in the same cycle.

Structure
REQ-028 Package serial_capture_pkg SHALL hold default WIDTH/DEPTH constants and the deserializer state enum (IDLE, SHIFT).
REQ-029 FIFO storage and pointers SHALL be a sub-module capture_fifo (sync FIFO, push/pop/full/empty/count); deserializer stays in serial_capture.

Verification
REQ-030 Bits 1,0,1,0,0,1,0,1 with bit_en=1 each cycle, out_ready=1 -> out_valid one cycle after bit 8, out_data=8'hA5, count 1 then 0.
REQ-031 bit_en toggled 1/0 for 16 cycles carrying 8'h3C -> word completes on 8th enabled bit only; out_data=8'h3C.
REQ-032 out_ready=0, push 5 words 8'h01..8'h05 (DEPTH=4) -> count=4, overflow=1, then draining yields 01,02,03,04 only.
REQ-033 FIFO full, out_ready=1 on the cycle the 5th word completes -> no overflow, count stays 4, drain order 02..05.
REQ-034 rst pulsed after 3 bits of a word -> outputs at reset values; next 8 bits 8'hFF form a clean word 8'hFF.
REQ-035 Continuous stream of 40 words with random out_ready stalls -> output sequence matches scoreboard, out_data stable during stalls, overflow only when model predicts a drop.
